// File: rtl/noise_pkg.sv
// noise_pkg: shared types and widths for the noise-table loader (NOISE_LOADER_TIMEOUT_EN adds the ERROR state).
package noise_pkg;
  localparam int NOISE_WORD_W         = 64;
  localparam int NOISE_LOC_W          = 8;
  localparam int NOISE_BYTES_PER_WORD = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef NOISE_LOADER_TIMEOUT_EN
    S_WAIT_DONE,
    S_ERROR
`else
    S_WAIT_DONE
`endif
  } noise_state_e;
endpackage

// File: rtl/noise_byte_packer.sv
// noise_byte_packer: assembles little-endian bytes into a 64-bit word; o_word includes the byte being accepted now.
module noise_byte_packer
  import noise_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic [7:0]              i_data,
  output logic [NOISE_WORD_W-1:0] o_word,
  output logic                    o_word_complete
);
  localparam int CNT_W = $clog2(NOISE_BYTES_PER_WORD);
  logic [CNT_W-1:0]        r_cnt;
  logic [NOISE_WORD_W-1:0] r_word;
  always_comb begin
    o_word = r_word;
    o_word[8*r_cnt +: 8] = i_data;
  end
  assign o_word_complete = i_accept && (r_cnt == CNT_W'(NOISE_BYTES_PER_WORD - 1));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_cnt  <= r_cnt + 1'b1;
      r_word <= o_word;
    end
  end
endmodule

// File: rtl/noise_table_loader.sv
// noise_table_loader: streams DEPTH 64-bit words into the noise block, then waits for done_wait.
// Optional NOISE_LOADER_TIMEOUT_EN bounds WAIT_DONE to TIMEOUT_CYC cycles and adds a sticky ERROR state.
module noise_table_loader
  import noise_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NOISE_WORD_W-1:0] mem_data,
  output logic [NOISE_LOC_W-1:0]  location,
  output logic                    load_mem,
  input  logic                    done_wait,
  output logic                    busy,
  output logic                    load_done,
  output logic                    timeout_err
);
  if (DEPTH < 1 || DEPTH > 256 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("noise_table_loader: DEPTH must be 1..256 and TIMEOUT_CYC >= 1");
  end
  localparam logic [NOISE_LOC_W-1:0] LAST = NOISE_LOC_W'(DEPTH - 1);
  noise_state_e            r_state, w_next;
  logic                    w_accept, w_clear, w_complete;
  logic [NOISE_WORD_W-1:0] w_word, r_mem_data;
  logic [NOISE_LOC_W-1:0]  r_idx, r_location;
  logic                    r_load_done;
`ifdef NOISE_LOADER_TIMEOUT_EN
  logic [31:0]             r_tcnt;
  logic                    r_timeout_err;
`endif
  assign in_ready  = (r_state == S_COLLECT) && !abort;
  assign w_accept  = in_valid && in_ready;
  assign w_clear   = abort || (r_state == S_IDLE && start);
  assign load_mem  = r_state == S_WRITE;
  assign busy      = r_state != S_IDLE;
  assign load_done = r_load_done;
  assign mem_data  = r_mem_data;
  assign location  = r_location;
  noise_byte_packer u_packer (
    .clk             (clk),
    .rstn            (rstn),
    .i_clear         (w_clear),
    .i_accept        (w_accept),
    .i_data          (in_data),
    .o_word          (w_word),
    .o_word_complete (w_complete)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (abort) w_next = S_IDLE;
    else case (r_state)
      S_IDLE:      w_next = start ? S_COLLECT : S_IDLE;
      S_COLLECT:   w_next = w_complete ? S_WRITE : S_COLLECT;
      S_WRITE:     w_next = (r_idx == LAST) ? S_WAIT_DONE : S_COLLECT;
`ifdef NOISE_LOADER_TIMEOUT_EN
      S_WAIT_DONE: w_next = done_wait ? S_IDLE :
                            (r_tcnt == 32'(TIMEOUT_CYC - 1)) ? S_ERROR : S_WAIT_DONE;
`else
      S_WAIT_DONE: w_next = done_wait ? S_IDLE : S_WAIT_DONE;
`endif
      default:     w_next = r_state;
    endcase
  end
  // r_idx is the next word slot; location only moves when a word is latched for WRITE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_data  <= '0;
      r_location  <= '0;
      r_idx       <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= (r_state == S_WAIT_DONE) && done_wait && !abort;
      if (r_state == S_IDLE && start && !abort) begin
        r_location <= '0;
        r_idx      <= '0;
      end else if (w_complete) begin
        r_mem_data <= w_word;
        r_location <= r_idx;
      end else if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end
`ifdef NOISE_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tcnt        <= (r_state == S_WAIT_DONE) ? r_tcnt + 32'd1 : '0;
      r_timeout_err <= w_next == S_ERROR;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_noise_table_loader.sv
// tb_noise_table_loader: randomized stimulus against a byte-count based reference model of the loader.
module tb_noise_table_loader;
  localparam int DEPTH = 4;
  localparam int TOC   = 16;
  localparam int NB    = 8 * DEPTH;
  logic        clk = 1'b0, rstn, start, abort, in_valid, in_ready, load_mem, done_wait, busy, load_done, timeout_err;
  logic [7:0]  in_data, location;
  logic [63:0] mem_data;
  int chk_m = 0, pass_m = 0, chk_l = 0, pass_l = 0;
  noise_table_loader #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_data(mem_data), .location(location),
    .load_mem(load_mem), .done_wait(done_wait), .busy(busy), .load_done(load_done),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  // model: a load is a count of accepted bytes; every 8th byte yields one write cycle
  bit          m_on, m_wr, m_wait, m_err, m_done;
  int          m_nb, m_tc;
  logic [7:0]  m_loc;
  logic [63:0] m_word;
  logic [7:0]  stream [0:NB-1];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_on = 0; m_wr = 0; m_wait = 0; m_err = 0; m_done = 0;
      m_nb = 0; m_tc = 0; m_loc = '0; m_word = '0;
    end else begin
      m_done = 0;
      if (abort) begin
        m_on = 0; m_wr = 0; m_wait = 0; m_err = 0;
      end else if (!m_on) begin
        if (start) begin m_on = 1; m_nb = 0; m_loc = '0; end
      end else if (m_err) begin
        m_err = 1;
      end else if (m_wr) begin
        m_wr = 0;
        if (m_nb == NB) begin m_wait = 1; m_tc = 0; end
      end else if (m_wait) begin
        if (done_wait) begin m_on = 0; m_wait = 0; m_done = 1; end
`ifdef NOISE_LOADER_TIMEOUT_EN
        else begin
          m_tc++;
          if (m_tc == TOC) begin m_err = 1; m_wait = 0; end
        end
`endif
      end else if (in_valid) begin
        stream[m_nb] = in_data;
        m_nb++;
        if (m_nb % 8 == 0) begin
          m_wr  = 1;
          m_loc = 8'(m_nb / 8 - 1);
          for (int j = 0; j < 8; j++) m_word[8*j +: 8] = stream[m_nb - 8 + j];
        end
      end
    end
  end
  logic [63:0] wr_word [0:255];
  logic [7:0]  wr_loc  [0:255];
  int          n_wr = 0;
  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    chk_m++;
    if (a === e) pass_m++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
  endtask
  always @(negedge clk) begin
    cmp("busy", 64'(busy), 64'(m_on));
    cmp("in_ready", 64'(in_ready), 64'(m_on && !m_wr && !m_wait && !m_err && !abort));
    cmp("load_mem", 64'(load_mem), 64'(m_wr));
    cmp("location", 64'(location), 64'(m_loc));
    cmp("mem_data", mem_data, m_word);
    cmp("load_done", 64'(load_done), 64'(m_done));
    cmp("timeout_err", 64'(timeout_err), 64'(m_err));
    if (load_mem === 1'b1 && n_wr < 256) begin
      wr_word[n_wr] = mem_data;
      wr_loc[n_wr]  = location;
      n_wr++;
    end
  end
  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
    chk_l++;
    if (a === e) pass_l++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
  endtask
  // vmode: 0 continuous, 1 toggled in_valid, 2 random in_valid plus stray starts while busy
  task automatic do_load(input int vmode, input bit rnd, input int abort_at, input int dw_delay, output int lat);
    logic [7:0] b [0:NB-1];
    int idx, cyc, dcnt, ab_cyc;
    bit acc;
    for (int i = 0; i < NB; i++) b[i] = rnd ? 8'($urandom) : 8'(i);
    idx = 0; dcnt = 0; lat = -1; ab_cyc = -1;
    start = 1; in_valid = 0; done_wait = (dw_delay == 0);
    @(posedge clk); #1;
    start = 0; cyc = 1;
    while (cyc < 3000) begin
      if (idx == NB) dcnt++;
      in_valid  = (idx < NB) && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                                 (vmode == 2 && $urandom_range(1, 0) == 1));
      in_data   = (idx < NB) ? b[idx] : 8'h00;
      abort     = (ab_cyc < 0 && abort_at >= 0 && idx == abort_at);
      if (abort) ab_cyc = cyc;
      start     = (vmode == 2 && $urandom_range(15, 0) == 0);
      done_wait = (dw_delay == 0) || (dcnt > dw_delay);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (load_done) begin lat = cyc; break; end
      if (ab_cyc >= 0 && cyc > ab_cyc + 20) break;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    start = 0; in_valid = 0; abort = 0; done_wait = 0;
  endtask
  int lat, b0;
  initial begin
    rstn = 0; start = 0; abort = 0; in_valid = 0; in_data = '0; done_wait = 0;
    #1;
    lit("rst_busy", 64'(busy), 64'd0);
    lit("rst_in_ready", 64'(in_ready), 64'd0);
    lit("rst_load_mem", 64'(load_mem), 64'd0);
    lit("rst_load_done", 64'(load_done), 64'd0);
    lit("rst_mem_data", mem_data, 64'd0);
    lit("rst_location", 64'(location), 64'd0);
    lit("rst_timeout_err", 64'(timeout_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    b0 = n_wr; do_load(0, 0, -1, 0, lat);
    lit("cont_latency", 64'(lat), 64'd38);
    lit("cont_writes", 64'(n_wr - b0), 64'd4);
    lit("cont_word0", wr_word[b0], 64'h0706050403020100);
    lit("cont_word3", wr_word[b0+3], 64'h1f1e1d1c1b1a1918);
    lit("cont_loc3", 64'(wr_loc[b0+3]), 64'd3);
    b0 = n_wr; do_load(1, 0, -1, 0, lat);
    lit("tog_writes", 64'(n_wr - b0), 64'd4);
    lit("tog_word1", wr_word[b0+1], 64'h0f0e0d0c0b0a0908);
    lit("tog_loc2", 64'(wr_loc[b0+2]), 64'd2);
    b0 = n_wr; do_load(0, 0, 13, 0, lat);
    lit("abort_no_done", 64'(lat), 64'hffffffffffffffff);
    lit("abort_writes", 64'(n_wr - b0), 64'd1);
    lit("abort_idle", 64'(busy), 64'd0);
    b0 = n_wr; do_load(0, 1, -1, 0, lat);
    lit("reload_loc0", 64'(wr_loc[b0]), 64'd0);
    lit("reload_latency", 64'(lat), 64'd38);
    b0 = n_wr; do_load(0, 0, -1, 51, lat);
`ifdef NOISE_LOADER_TIMEOUT_EN
    lit("timeout_set", 64'(timeout_err), 64'd1);
    abort = 1; @(posedge clk); #1 abort = 0;
    lit("timeout_clr", 64'(timeout_err), 64'd0);
`else
    lit("late_done_latency", 64'(lat), 64'd88);
    lit("no_timeout", 64'(timeout_err), 64'd0);
`endif
    repeat (6) begin
      do_load(2, 1, -1, $urandom_range(5, 0), lat);
      lit("rand_completed", 64'(lat >= 38), 64'd1);
    end
    start = 1; @(posedge clk); #1 start = 0;
    in_valid = 1;
    repeat (12) begin in_data = 8'($urandom); @(posedge clk); #1; end
    #2 rstn = 0;
    #1;
    lit("arst_busy", 64'(busy), 64'd0);
    lit("arst_in_ready", 64'(in_ready), 64'd0);
    lit("arst_mem_data", mem_data, 64'd0);
    lit("arst_location", 64'(location), 64'd0);
    lit("arst_load_mem", 64'(load_mem), 64'd0);
    in_valid = 0;
    @(posedge clk); #1 rstn = 1;
    b0 = n_wr; do_load(0, 1, -1, 0, lat);
    lit("post_rst_loc0", 64'(wr_loc[b0]), 64'd0);
    lit("post_rst_latency", 64'(lat), 64'd38);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_m + pass_l, chk_m + chk_l);
    $finish;
  end
endmodule
